// File: rtl/bus_pkg.sv
// Shared types and defaults for the memory-port arbiter.
// The arbiter FSM states and the round-robin winner pick live here.
package bus_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Winner index: on a tie the requester not granted last wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
    if (req == 2'b11) begin
      return ~last_grant;
    end
    return req[1];
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Counts ACCESS cycles spent without mem_ready.
// expired flags the cycle that would be the TIMEOUT-th unanswered one.
module wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  assign expired = enable && (count_reg == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a single memory port with
// a bounded wait for mem_ready and one-cycle done/err responses.
module mem_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        req_wr,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [1:0]        err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_e            state_reg;
  logic              winner_reg;
  logic              last_grant_reg;
  logic              wr_reg;
  logic              ok_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic pick;
  logic in_access;
  logic in_resp;
  logic timer_clear;
  logic timer_enable;
  logic expired;

  assign pick         = rr_pick(req, last_grant_reg);
  assign in_access    = (state_reg == ACCESS);
  assign in_resp      = (state_reg == RESP);
  assign timer_clear  = (state_reg == IDLE) && (|req);
  assign timer_enable = in_access && !mem_ready;

  wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      winner_reg     <= 1'b0;
      last_grant_reg <= 1'b1;
      wr_reg         <= 1'b0;
      ok_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      rdata_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|req) begin
            winner_reg <= pick;
            wr_reg     <= req_wr[pick];
            addr_reg   <= pick ? req_addr1 : req_addr0;
            wdata_reg  <= pick ? req_wdata1 : req_wdata0;
            state_reg  <= ACCESS;
          end
        end
        ACCESS: begin
          // A ready arriving on the last allowed cycle still counts as success.
          if (mem_ready) begin
            ok_reg <= 1'b1;
            if (!wr_reg) begin
              rdata_reg <= mem_rdata;
            end
            state_reg <= RESP;
          end else if (expired) begin
            ok_reg    <= 1'b0;
            state_reg <= RESP;
          end
        end
        RESP: begin
          last_grant_reg <= winner_reg;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Per-requester decode of grant and response pulses from the owner.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic sel;
    assign sel      = (winner_reg == 1'(gi));
    assign gnt[gi]  = in_access && sel;
    assign done[gi] = in_resp && ok_reg && sel;
    assign err[gi]  = in_resp && !ok_reg && sel;
  end

  assign mem_rd    = in_access && !wr_reg;
  assign mem_wr    = in_access && wr_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign rdata     = rdata_reg;

endmodule
